intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): Clk  in  1  single clock, all state changes on posedge Clk.
REQ-002 SHALL have Reset  in  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-003 SHALL have fintr_req  in  2  fast interrupt request levels; bit d from IO module d (fintr_check).
REQ-004 SHALL have intr_req  in  2  normal interrupt request levels; bit d from IO module d (intr_check).
REQ-005 SHALL have cpu_ack  in  1  one-cycle pulse; CPU accepts the pending interrupt.
REQ-006 SHALL have cpu_done  in  1  one-cycle pulse; CPU has returned from the current ISR.
REQ-007 SHALL have cpu_fiq  out  1  fast interrupt line to the CPU.
REQ-008 SHALL have cpu_irq  out  1  normal interrupt line to the CPU.
REQ-009 SHALL have isr_vec  out  2  {fast, device}: source of the pending or active interrupt.
REQ-010 SHALL have int_ack  out  2  one-cycle acknowledge pulse to device d.
REQ-011 SHALL have Enable  out  2  bus enable for IO module d while its ISR runs.
REQ-012 All outputs SHALL be registered.

Function
REQ-013 States SHALL be IDLE, REQ, ACK, SVC, plus FREQ, FACK, FSVC for nesting.
REQ-014 Priority SHALL be fintr_req[0] > fintr_req[1] > intr_req[0] > intr_req[1].
REQ-015 IDLE: on any request high at edge N, the winner SHALL be latched into isr_vec and state SHALL go to REQ; cpu_fiq (fast) or cpu_irq (normal) SHALL be high after edge N.
REQ-016 REQ: if the latched request is low at an edge without cpu_ack, state SHALL return to IDLE and the CPU line SHALL drop, with no int_ack.
REQ-017 REQ: cpu_ack SHALL drop the CPU line, go to ACK, and assert int_ack[dev] for exactly one cycle.
REQ-018 ACK SHALL go to SVC unconditionally; Enable[dev] SHALL be high from ACK entry until the cycle after cpu_done.
REQ-019 SVC: cpu_done SHALL clear Enable and isr_vec and return to IDLE; new arbitration SHALL start no earlier than the following edge.
REQ-020 The serviced source SHALL NOT be re-requested before cpu_done, even if its device re-raises immediately after int_ack.
REQ-021 cpu_ack outside REQ/FREQ and cpu_done outside SVC/FSVC SHALL be ignored; Enable SHALL be one-hot or zero.
REQ-022 Simultaneous fast and normal requests SHALL always grant fast first.

Reset
REQ-023 Reset SHALL force IDLE, cpu_fiq=0, cpu_irq=0, isr_vec=0, int_ack=0, Enable=0, and clear the saved nesting context, including mid-handshake or mid-ISR.
REQ-024 Requests high during Reset SHALL be arbitrated at the first edge after Reset is released.

Configuration
REQ-025 With macro INTR_NEST_EN defined: in normal SVC, any fast request SHALL save {dev} and go to FREQ, FACK, then FSVC, following REQ-015..REQ-019 with cpu_fiq. Enable SHALL switch to the fast device, and FSVC cpu_done SHALL restore SVC with the saved vector and Enable. Nesting depth SHALL be 2, and fast SHALL NOT preempt fast.
REQ-026 Without INTR_NEST_EN: FREQ, FACK, and FSVC SHALL be absent, and fast requests SHALL wait until IDLE.

Verification
REQ-027 intr_req=01 -> cpu_irq=1, isr_vec=00; cpu_ack -> int_ack=01 one cycle, Enable=01; cpu_done -> Enable=00, IDLE.
REQ-028 fintr_req=10 and intr_req=01 in the same cycle -> cpu_fiq=1, isr_vec=11 first; the normal request is served after cpu_done.
REQ-029 intr_req=10 raised, then dropped before cpu_ack -> cpu_irq returns to 0 and int_ack stays 00.
REQ-030 INTR_NEST_EN defined, SVC for intr dev0, then fintr_req=10 -> cpu_fiq=1; cpu_ack -> Enable=10; cpu_done -> Enable=01, isr_vec=00. Without the macro -> cpu_fiq stays 0 until the first cpu_done.
REQ-031 Reset asserted in FSVC or ACK -> all outputs 0 at the next edge; a pending request is regranted after release.
REQ-032 Device re-raises intr_req[1] on int_ack -> no new cpu_irq until the cycle after cpu_done.

Source files
------------

// File: rtl/intr_ctrl_if.sv
// Interrupt controller bus: device request levels and CPU handshake in,
// CPU interrupt lines, vector, device acknowledges and bus enables out.
interface intr_ctrl_if;
    logic [1:0] fintr_req;
    logic [1:0] intr_req;
    logic       cpu_ack;
    logic       cpu_done;
    logic       cpu_fiq;
    logic       cpu_irq;
    logic [1:0] isr_vec;
    logic [1:0] int_ack;
    logic [1:0] Enable;

    // Requesters (devices and CPU) drive the master side.
    modport master (
        output fintr_req, intr_req, cpu_ack, cpu_done,
        input  cpu_fiq, cpu_irq, isr_vec, int_ack, Enable
    );

    // The controller sits on the slave side.
    modport slave (
        input  fintr_req, intr_req, cpu_ack, cpu_done,
        output cpu_fiq, cpu_irq, isr_vec, int_ack, Enable
    );
endinterface

// File: rtl/intr_ctrl.sv
// Two-device fixed-priority interrupt controller with fast/normal lines.
// Optional macro INTR_NEST_EN lets a fast request preempt a normal ISR.
module intr_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    intr_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ACK  = 3'd2,
`ifdef INTR_NEST_EN
        ST_SVC  = 3'd3,
        ST_FREQ = 3'd4,
        ST_FACK = 3'd5,
        ST_FSVC = 3'd6
`else
        ST_SVC  = 3'd3
`endif
    } state_t;

    // Result is {valid, fast, dev}; fast sources always outrank normal ones.
    function automatic logic [2:0] f_arbitrate(input logic [1:0] fq, input logic [1:0] nq);
        logic [2:0] res;
        res = 3'b000;
        if (fq[0]) begin
            res = 3'b110;
        end else if (fq[1]) begin
            res = 3'b111;
        end else if (nq[0]) begin
            res = 3'b100;
        end else if (nq[1]) begin
            res = 3'b101;
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    function automatic logic [1:0] f_onehot(input logic dev);
        logic [1:0] res;
        if (dev) begin
            res = 2'b10;
        end else begin
            res = 2'b01;
        end
        return res;
    endfunction

    state_t     state_r;
    logic       cpu_fiq_r;
    logic       cpu_irq_r;
    logic [1:0] isr_vec_r;
    logic [1:0] int_ack_r;
    logic [1:0] enable_r;
    logic [2:0] arb_s;
    logic       cur_req_s;
`ifdef INTR_NEST_EN
    logic       saved_dev_r;
    logic [2:0] fast_arb_s;
`endif

    // Full arbitration for IDLE and the level of the currently latched source.
    always_comb begin
        arb_s     = f_arbitrate(bus.fintr_req, bus.intr_req);
        cur_req_s = 1'b0;
        if (isr_vec_r[1]) begin
            cur_req_s = bus.fintr_req[isr_vec_r[0]];
        end else begin
            cur_req_s = bus.intr_req[isr_vec_r[0]];
        end
    end

`ifdef INTR_NEST_EN
    // Fast-only arbitration used to preempt a running normal ISR.
    always_comb begin
        fast_arb_s = f_arbitrate(bus.fintr_req, 2'b00);
    end
`endif

    // Handshake FSM; every output is a register written here.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            cpu_fiq_r   <= 1'b0;
            cpu_irq_r   <= 1'b0;
            isr_vec_r   <= 2'b00;
            int_ack_r   <= 2'b00;
            enable_r    <= 2'b00;
`ifdef INTR_NEST_EN
            saved_dev_r <= 1'b0;
`endif
        end else begin
            int_ack_r <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    if (arb_s[2]) begin
                        isr_vec_r <= arb_s[1:0];
                        cpu_fiq_r <= arb_s[1];
                        cpu_irq_r <= ~arb_s[1];
                        state_r   <= ST_REQ;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus.cpu_ack) begin
                        cpu_fiq_r <= 1'b0;
                        cpu_irq_r <= 1'b0;
                        int_ack_r <= f_onehot(isr_vec_r[0]);
                        enable_r  <= f_onehot(isr_vec_r[0]);
                        state_r   <= ST_ACK;
                    end else if (!cur_req_s) begin
                        // Source withdrew before the CPU took it: no acknowledge.
                        cpu_fiq_r <= 1'b0;
                        cpu_irq_r <= 1'b0;
                        isr_vec_r <= 2'b00;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_REQ;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_SVC;
                end
                ST_SVC: begin
                    if (bus.cpu_done) begin
                        enable_r  <= 2'b00;
                        isr_vec_r <= 2'b00;
                        state_r   <= ST_IDLE;
`ifdef INTR_NEST_EN
                    end else if (fast_arb_s[2] && !isr_vec_r[1]) begin
                        saved_dev_r <= isr_vec_r[0];
                        isr_vec_r   <= fast_arb_s[1:0];
                        cpu_fiq_r   <= 1'b1;
                        state_r     <= ST_FREQ;
`endif
                    end else begin
                        state_r   <= ST_SVC;
                    end
                end
`ifdef INTR_NEST_EN
                ST_FREQ: begin
                    if (bus.cpu_ack) begin
                        cpu_fiq_r <= 1'b0;
                        int_ack_r <= f_onehot(isr_vec_r[0]);
                        enable_r  <= f_onehot(isr_vec_r[0]);
                        state_r   <= ST_FACK;
                    end else if (!cur_req_s) begin
                        // Fast source withdrew: resume the interrupted normal ISR.
                        cpu_fiq_r <= 1'b0;
                        isr_vec_r <= {1'b0, saved_dev_r};
                        state_r   <= ST_SVC;
                    end else begin
                        state_r   <= ST_FREQ;
                    end
                end
                ST_FACK: begin
                    state_r <= ST_FSVC;
                end
                ST_FSVC: begin
                    if (bus.cpu_done) begin
                        isr_vec_r   <= {1'b0, saved_dev_r};
                        enable_r    <= f_onehot(saved_dev_r);
                        saved_dev_r <= 1'b0;
                        state_r     <= ST_SVC;
                    end else begin
                        state_r     <= ST_FSVC;
                    end
                end
`endif
                default: begin
                    state_r   <= ST_IDLE;
                    cpu_fiq_r <= 1'b0;
                    cpu_irq_r <= 1'b0;
                    isr_vec_r <= 2'b00;
                    int_ack_r <= 2'b00;
                    enable_r  <= 2'b00;
                end
            endcase
        end
    end

    assign bus.cpu_fiq = cpu_fiq_r;
    assign bus.cpu_irq = cpu_irq_r;
    assign bus.isr_vec = isr_vec_r;
    assign bus.int_ack = int_ack_r;
    assign bus.Enable  = enable_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Table-driven bench for intr_ctrl with an expected-value queue, plus a
// hand-written handshake sequence; expectations follow INTR_NEST_EN.
module tb_intr_ctrl;

    typedef struct {
        logic [1:0] fq;
        logic [1:0] nq;
        logic       ack;
        logic       done;
        logic       rst;
        logic [7:0] exp;   // {fiq, irq, isr_vec, int_ack, Enable}
    } vec_t;

    logic Clk;
    logic Reset;
    intr_ctrl_if bus ();

    intr_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         n_pass;
    int         n_total;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] outs();
        return {bus.cpu_fiq, bus.cpu_irq, bus.isr_vec, bus.int_ack, bus.Enable};
    endfunction

    task automatic add(input logic [1:0] fq, input logic [1:0] nq, input logic ack,
                       input logic done, input logic rst, input logic fiq, input logic irq,
                       input logic [1:0] vec, input logic [1:0] iack, input logic [1:0] en);
        vec_t v;
        v.fq = fq; v.nq = nq; v.ack = ack; v.done = done; v.rst = rst;
        v.exp = {fiq, irq, vec, iack, en};
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_total++;
        if (got !== want) begin
            $display("FAIL %s: got %b required %b", nm, got, want);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic [1:0] fq, input logic [1:0] nq, input logic ack,
                         input logic done, input logic rst);
        @(negedge Clk);
        bus.fintr_req = fq;
        bus.intr_req  = nq;
        bus.cpu_ack   = ack;
        bus.cpu_done  = done;
        Reset         = rst;
    endtask

    initial begin
        logic [7:0] want;
        bit         seen;
        n_pass = 0;
        n_total = 0;
        Reset = 1'b1;
        bus.fintr_req = 2'b00;
        bus.intr_req  = 2'b00;
        bus.cpu_ack   = 1'b0;
        bus.cpu_done  = 1'b0;

        //   fq     nq     ack   done  rst   fiq   irq   vec    iack   en
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        // normal dev0 full handshake
        add(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        add(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        // fast dev1 and normal dev0 together: fast first, normal after done
        add(2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
        add(2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 2'b10);
        add(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b10);
        add(2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        add(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        // request withdrawn before ack
        add(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        // device re-raises right after int_ack
        add(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00);
        add(2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10);
        add(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10);
        add(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10);
        add(2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00);
        add(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10);
        add(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        // full priority, fast withdrawal, normal priority, stray ack/done
        add(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        // reset in ACK, pending request regranted after release
        add(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01);
        add(2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        // fast request while normal dev0 is in service
`ifdef INTR_NEST_EN
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b01);
        add(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 2'b10);
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b10);
        add(2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b01);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        add(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
`else
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        add(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        add(2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
`endif
        // reset during the (nested) fast ISR, fast request regranted after release
        add(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01);
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
`ifdef INTR_NEST_EN
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b01);
        add(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 2'b10);
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b10);
`else
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        add(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
`endif
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
        add(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 2'b10);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b10);
        add(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);

        foreach (vecs[i]) begin
            drive(vecs[i].fq, vecs[i].nq, vecs[i].ack, vecs[i].done, vecs[i].rst);
            exp_q.push_back(vecs[i].exp);
            @(posedge Clk);
            #1;
            want = exp_q.pop_front();
            check($sformatf("vec%0d", i), outs(), want);
        end

        // Hand sequence: bounded wait for cpu_irq, held request, one-cycle int_ack.
        drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk);
            #1;
            if (bus.cpu_irq === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("irq_wait", {7'd0, seen}, 8'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk);
            #1;
            check($sformatf("irq_hold%0d", k), outs(), 8'b01_00_00_00);
        end
        drive(2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        check("ack_pulse", outs(), 8'b00_00_01_01);
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        check("ack_clear", outs(), 8'b00_00_00_01);
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        @(posedge Clk);
        #1;
        check("done_clear", outs(), 8'b00_00_00_00);
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        check("idle_after", outs(), 8'b00_00_00_00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
